// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, per-channel stability counter,
// clean debounced level plus registered press/release pulses and a press toggle.
module button_debouncer #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] BTN_RAW,
  output logic [N_BTN-1:0] BTN_STATE,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic [N_BTN-1:0] BTN_TOGGLE
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } ch_state_e;

  logic [N_BTN-1:0]         s1, s2;
  logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;
  ch_state_e                ch_state [N_BTN];
  logic [N_BTN-1:0]         accept;
  logic [N_BTN-1:0]         state_d, press_d, release_d, toggle_d;

  // State register: synchronizer, counters and all registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1          <= '0;
      s2          <= '0;
      cnt_q       <= '0;
      BTN_STATE   <= '0;
      BTN_PRESS   <= '0;
      BTN_RELEASE <= '0;
      BTN_TOGGLE  <= '0;
    end else begin
      s1          <= BTN_RAW;
      s2          <= s1;
      cnt_q       <= cnt_d;
      BTN_STATE   <= state_d;
      BTN_PRESS   <= press_d;
      BTN_RELEASE <= release_d;
      BTN_TOGGLE  <= toggle_d;
    end
  end

  // Channel state is implied by s2 vs. the accepted level; a mismatch that ends
  // early returns to STABLE and clears the count (no partial credit).
  always_comb begin
    cnt_d  = '0;
    accept = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      ch_state[i] = (s2[i] != BTN_STATE[i]) ? PENDING : STABLE;
      case (ch_state[i])
        PENDING: begin
          if (cnt_q[i] == CNT_MAX) begin
            accept[i] = 1'b1;
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  // Acceptance only happens on a mismatch, so the new level is simply s2.
  always_comb begin
    state_d   = BTN_STATE ^ accept;
    press_d   = accept & s2;
    release_d = accept & ~s2;
    toggle_d  = BTN_TOGGLE ^ press_d;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: vector table, directed corner
// sequences and randomized bouncing inputs against a windowed reference model.
module tb_button_debouncer;

  localparam int N  = 4;
  localparam int DC = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [N-1:0] BTN_RAW;
  logic [N-1:0] BTN_STATE, BTN_PRESS, BTN_RELEASE, BTN_TOGGLE;

  button_debouncer #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_RAW(BTN_RAW),
    .BTN_STATE(BTN_STATE), .BTN_PRESS(BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE), .BTN_TOGGLE(BTN_TOGGLE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: a level is accepted once the last DC synchronized samples
  // all agree and differ from the current accepted level.
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0] m_state = '0, m_press = '0, m_rel = '0, m_tog = '0;
  logic [N-1:0] hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit all_same;
    if (!RST_N) begin
      m_s1 = '0; m_s2 = '0; m_state = '0; m_press = '0; m_rel = '0; m_tog = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > DC) void'(hist.pop_front());
      m_press = '0;
      m_rel   = '0;
      if (hist.size() == DC) begin
        for (int i = 0; i < N; i++) begin
          all_same = 1'b1;
          for (int j = 0; j < DC; j++)
            if (hist[j][i] != hist[DC-1][i]) all_same = 1'b0;
          if (all_same && hist[DC-1][i] != m_state[i]) begin
            m_state[i] = hist[DC-1][i];
            if (m_state[i]) begin
              m_press[i] = 1'b1;
              m_tog[i]   = ~m_tog[i];
            end else begin
              m_rel[i] = 1'b1;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = BTN_RAW;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    check("model_state",   BTN_STATE,   m_state);
    check("model_press",   BTN_PRESS,   m_press);
    check("model_release", BTN_RELEASE, m_rel);
    check("model_toggle",  BTN_TOGGLE,  m_tog);
    if ((BTN_PRESS & BTN_RELEASE) != '0) check("press_and_release", BTN_PRESS & BTN_RELEASE, 0);
  endtask

  task automatic do_reset(input int n);
    RST_N = 1'b0;
    repeat (n) step();
    RST_N = 1'b1;
  endtask

  // Steps until any bit of mask shows on the chosen event bus; n = edges taken.
  task automatic wait_event(input logic [N-1:0] mask, input bit is_press, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((((is_press ? BTN_PRESS : BTN_RELEASE) & mask) == '0) && n < 40);
  endtask

  typedef struct {
    logic         rst_n;
    logic [N-1:0] raw;
    int           hold;
    logic [N-1:0] st, pr, rl, tg;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int n;
    logic [N-1:0] seen;
    int hold_left [N];

    RST_N   = 1'b0;
    BTN_RAW = '0;

    // Reset with all buttons held, release, then a clean global release and short bursts.
    tbl.push_back('{1'b0, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'hF, 9, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'hF, 1, 4'hF, 4'hF, 4'h0, 4'hF});
    tbl.push_back('{1'b1, 4'hF, 1, 4'hF, 4'h0, 4'h0, 4'hF});
    tbl.push_back('{1'b1, 4'h0, 9, 4'hF, 4'h0, 4'h0, 4'hF});
    tbl.push_back('{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'hF, 4'hF});
    tbl.push_back('{1'b1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back('{1'b1, 4'h5, 5, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back('{1'b1, 4'h0, 20, 4'h0, 4'h0, 4'h0, 4'hF});

    foreach (tbl[k]) begin
      RST_N   = tbl[k].rst_n;
      BTN_RAW = tbl[k].raw;
      repeat (tbl[k].hold) step();
      check("tbl_state",   BTN_STATE,   tbl[k].st);
      check("tbl_press",   BTN_PRESS,   tbl[k].pr);
      check("tbl_release", BTN_RELEASE, tbl[k].rl);
      check("tbl_toggle",  BTN_TOGGLE,  tbl[k].tg);
    end

    // Clean press/release on channel 0.
    do_reset(2);
    BTN_RAW = 4'h1;
    wait_event(4'h1, 1'b1, n);
    check("clean_press_latency", n, 10);
    check("clean_press_toggle", BTN_TOGGLE[0], 1);
    step();
    check("clean_press_single", BTN_PRESS[0], 0);
    repeat (20 - n - 1) step();
    BTN_RAW = 4'h0;
    wait_event(4'h1, 1'b0, n);
    check("clean_release_latency", n, 10);
    step();
    check("clean_release_single", BTN_RELEASE[0], 0);
    check("clean_release_toggle", BTN_TOGGLE[0], 1);

    // Bounce on channel 1: restart of the full count.
    do_reset(2);
    seen = '0;
    BTN_RAW = 4'h2;
    repeat (5) begin step(); seen |= BTN_PRESS | BTN_RELEASE; end
    BTN_RAW = 4'h0;
    repeat (2) begin step(); seen |= BTN_PRESS | BTN_RELEASE; end
    BTN_RAW = 4'h2;
    check("bounce_no_event", seen, 0);
    wait_event(4'h2, 1'b1, n);
    check("bounce_press_latency", n, 10);

    // 7-cycle glitch on channel 2.
    do_reset(2);
    seen = '0;
    BTN_RAW = 4'h4;
    repeat (7) begin step(); seen |= BTN_PRESS | BTN_RELEASE; end
    BTN_RAW = 4'h0;
    repeat (15) begin step(); seen |= BTN_PRESS | BTN_RELEASE | BTN_STATE; end
    check("glitch_no_change", seen, 0);

    // Simultaneous channels, two full press/release rounds.
    do_reset(2);
    BTN_RAW = 4'hA;
    wait_event(4'hF, 1'b1, n);
    check("simul_press_mask", BTN_PRESS, 4'hA);
    check("simul_press_latency", n, 10);
    check("simul_toggle_1", BTN_TOGGLE, 4'hA);
    BTN_RAW = 4'h0;
    wait_event(4'hF, 1'b0, n);
    check("simul_release_mask", BTN_RELEASE, 4'hA);
    BTN_RAW = 4'hA;
    wait_event(4'hF, 1'b1, n);
    BTN_RAW = 4'h0;
    wait_event(4'hF, 1'b0, n);
    check("simul_toggle_2", BTN_TOGGLE, 4'h0);

    // Reset mid-count with channel 3 held through reset.
    do_reset(2);
    seen = '0;
    BTN_RAW = 4'h8;
    repeat (5) begin step(); seen |= BTN_PRESS; end
    check("midreset_no_early_press", seen, 0);
    do_reset(2);
    wait_event(4'h8, 1'b1, n);
    check("midreset_press_latency", n, 10);
    check("midreset_toggle", BTN_TOGGLE[3], 1);

    // Randomized bouncing inputs with occasional resets.
    do_reset(2);
    for (int i = 0; i < N; i++) hold_left[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold_left[i] == 0) begin
          BTN_RAW[i]   = ~BTN_RAW[i];
          hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 10);
        end
        hold_left[i]--;
      end
      RST_N = ($urandom_range(0, 599) != 0);
      step();
    end
    RST_N = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Input conditioner for the board push-buttons: synchronizes raw button levels into the clock domain, debounces each channel independently, and reports clean levels, one-cycle press/release events and a per-button toggle bit. It sits between the top-level button pins and any logic or LEDs that consume button state. It replaces direct pin-to-LED wiring wherever edge events or bounce-free levels are needed. Active-low pins such as BTN_N are inverted by the instantiating module before entering BTN_RAW.

## Interface
- N_BTN, 4: number of independent button channels (1..8).
- DEBOUNCE_CYCLES, 120000: clocks a synchronized level must remain stable before acceptance (10 ms at 12 MHz); legal range 2..2^24.
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- BTN_RAW  input  N_BTN  asynchronous raw button levels, active-high (1 = pressed).
- BTN_STATE  output  N_BTN  debounced level per channel.
- BTN_PRESS  output  N_BTN  one-cycle pulse on accepted 0->1 transition.
- BTN_RELEASE  output  N_BTN  one-cycle pulse on accepted 1->0 transition.
- BTN_TOGGLE  output  N_BTN  flips on every accepted press; intended to drive LEDs.

## Operation
- Per channel: two-flop synchronizer (s1 <= BTN_RAW[i], s2 <= s1), stability counter cnt of width clog2(DEBOUNCE_CYCLES), debounced register BTN_STATE[i].
- Two states per channel, encoded by comparing s2 with BTN_STATE[i]:
  - STABLE (s2 == BTN_STATE[i]): cnt <= 0; no events.
  - PENDING (s2 != BTN_STATE[i]): if cnt == DEBOUNCE_CYCLES-1, then BTN_STATE[i] <= s2, cnt <= 0, event fires; otherwise cnt <= cnt + 1.
- Any return of s2 to BTN_STATE[i] before the count completes drops the channel to STABLE and clears cnt. A bounce restarts the full count; there is no partial credit.
- Event on acceptance: BTN_PRESS[i] <= 1 if new level is 1, BTN_RELEASE[i] <= 1 if new level is 0; both are 0 in every other cycle. BTN_TOGGLE[i] <= ~BTN_TOGGLE[i] on press only.
- Channels are fully independent. Simultaneous events on several channels all assert in the same cycle.
- Counter never wraps: maximum value DEBOUNCE_CYCLES-1, then reset to 0.
- Reset (RST_N == 0 at a rising edge): s1, s2, cnt, BTN_STATE, BTN_PRESS, BTN_RELEASE and BTN_TOGGLE all go to 0. Reset mid-count discards the pending transition. A button held through reset release is reported as a fresh press after the full latency.

## Timing
- All outputs are registered; no combinational path from BTN_RAW to any output.
- Reset value of every output: 0.
- Latency: BTN_RAW changes before edge k and stays stable. s2 shows the new value after edge k+1. BTN_STATE and the event pulse update at edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges counting edge k.
- BTN_PRESS and BTN_RELEASE are high for exactly one clock and never both high on one channel.
- BTN_TOGGLE changes in the same cycle as BTN_PRESS asserts.
- Minimum spacing between two accepted events on one channel: DEBOUNCE_CYCLES clocks.
- A glitch shorter than DEBOUNCE_CYCLES clocks after synchronization produces no output change.

## Test plan
Test bench settings: N_BTN=4, DEBOUNCE_CYCLES=8.
- Reset check: hold RST_N=0 for 3 clocks with BTN_RAW=4'hF. Required: all outputs 0 during reset. After release, BTN_STATE=4'hF and BTN_PRESS=4'hF for one cycle, exactly 10 edges after the first non-reset edge.
- Clean press/release: BTN_RAW[0] 0->1, held for 20 clocks, then 1->0. Required: BTN_PRESS[0] is a single pulse 10 edges after the rise, BTN_TOGGLE[0]=1. BTN_RELEASE[0] is a single pulse 10 edges after the fall, BTN_TOGGLE[0] stays 1.
- Bounce rejection: on BTN_RAW[1], apply high for 5 clocks, low for 2, high for 7, then hold high. Required: no event during bounce; BTN_PRESS[1] fires 10 edges after the final rise.
- Glitch: 7-clock high pulse on BTN_RAW[2]. Required: BTN_STATE[2] stays 0 and no pulses.
- Simultaneous channels: BTN_RAW 4'h0 -> 4'hA in one cycle. Required: BTN_PRESS=4'hA in a single cycle and BTN_TOGGLE=4'hA. Repeat the press-release sequence once more; required BTN_TOGGLE=4'h0.
- Reset mid-count: assert RST_N=0 five clocks into a pending press on BTN_RAW[3], then release with the button still held. Required: no pulse before reset; BTN_PRESS[3] fires 10 edges after reset release; BTN_TOGGLE[3]=1.
